// File: rtl/config_access_controller_pkg.sv
// config_access_controller_pkg: shared types and constants for the config access controller.
package config_access_controller_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_P, WAIT_Q, DONE, LOCKED} state_t;
    localparam int KEY_W = 8;
    localparam int DATA_W = 7;
    localparam int DEF_MAX_ATTEMPTS = 3;
    localparam int DEF_LOCKOUT_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
    localparam int CNT_W = cnt_width(DEF_LOCKOUT_CYCLES, DEF_TIMEOUT_CYCLES);
endpackage

// File: rtl/config_access_controller_cycle_timer.sv
// cycle_timer: clearable up-counter flagging the last cycle of a limit-long window.
module cycle_timer
    import config_access_controller_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    // The edge that would take the count to limit is the edge that ends the window.
    assign expired = cnt == limit - 1'b1;
endmodule

// File: rtl/config_access_controller.sv
// config_access_controller: key-gated sequencer driving the P/Q register write enables,
// with failed-attempt lockout and a stalled-session timeout.
module config_access_controller
    import config_access_controller_pkg::*;
#(
    parameter int MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             request,
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] storedKey,
    input  logic             confirm,
    input  logic [7:0]       inputData,
    output logic             writeRegP,
    output logic             writeRegQ,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             error,
    output logic [1:0]       attempts
);
    localparam int CW = cnt_width(LOCKOUT_CYCLES, TIMEOUT_CYCLES);
    state_t state, state_n;
    logic [1:0] attempts_n, att_inc;
    logic error_n, good_key, waiting, ok_data, bad_data, key_fail, lock_now, timeout, expired;
    logic unused_payload;
    assign unused_payload = ^inputData[DATA_W-1:0];
    assign good_key = key == storedKey;
    assign waiting = state == WAIT_P || state == WAIT_Q;
    assign ok_data = confirm & ~inputData[7];
    assign bad_data = confirm & inputData[7];
    assign att_inc = attempts + 2'd1;
    assign key_fail = state == IDLE && request && !good_key;
    assign lock_now = key_fail && att_inc == 2'(MAX_ATTEMPTS);
    // A rejected confirm still counts as activity, so it never times out on the same edge.
    assign timeout = waiting && !confirm && expired;
    // Timeout and lockout never overlap, so one timer serves both.
    cycle_timer #(.W(CW)) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (state_n != state || (waiting && bad_data)),
        .en     (waiting || state == LOCKED),
        .limit  (state == LOCKED ? CW'(LOCKOUT_CYCLES) : CW'(TIMEOUT_CYCLES)),
        .expired(expired)
    );
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !request ? IDLE : good_key ? WAIT_P : lock_now ? LOCKED : IDLE;
            WAIT_P:  state_n = ok_data ? WAIT_Q : timeout ? IDLE : WAIT_P;
            WAIT_Q:  state_n = ok_data ? DONE : timeout ? IDLE : WAIT_Q;
            DONE:    state_n = IDLE;
            LOCKED:  state_n = expired ? IDLE : LOCKED;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        writeRegP = state == WAIT_P && ok_data;
        writeRegQ = state == WAIT_Q && ok_data;
        error_n = key_fail || timeout || (waiting && bad_data);
        attempts_n = (state == LOCKED && expired) || (state == IDLE && request && good_key) ? 2'd0
                   : key_fail ? att_inc : attempts;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            attempts <= 2'd0;
            error <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
            locked <= 1'b0;
        end else begin
            attempts <= attempts_n;
            error <= error_n;
            done <= state_n == DONE;
            busy <= state_n != IDLE;
            locked <= state_n == LOCKED;
        end
    end
endmodule

// File: tb/tb_config_access_controller.sv
// tb_config_access_controller: directed self-checking bench for config_access_controller.
module tb_config_access_controller;
    logic clock = 0, resetn = 1, request = 0, confirm = 0;
    logic [7:0] key = 0, storedKey = 8'hA5, inputData = 0;
    logic writeRegP, writeRegQ, busy, locked, done, error;
    logic [1:0] attempts;
    logic [7:0] outs;
    logic [6:0] regp = 0, regq = 0;
    int np = 0, nq = 0, both = 0, compared = 0, mismatched = 0;
    int p0, q0, lk;

    config_access_controller dut (
        .clock(clock), .resetn(resetn), .request(request), .key(key), .storedKey(storedKey),
        .confirm(confirm), .inputData(inputData), .writeRegP(writeRegP), .writeRegQ(writeRegQ),
        .busy(busy), .locked(locked), .done(done), .error(error), .attempts(attempts)
    );

    always #5 clock = ~clock;
    assign outs = {writeRegP, writeRegQ, busy, locked, done, error, attempts};

    // Stand-in for the two configuration registers.
    always @(posedge clock) begin
        if (writeRegP) begin regp <= inputData[6:0]; np <= np + 1; end
        if (writeRegQ) begin regq <= inputData[6:0]; nq <= nq + 1; end
        if (writeRegP && writeRegQ) both <= both + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2 resetn = 0;
        #1 chk("reset_outs", outs, 8'h00);
        tick();
        resetn = 1;
        tick();
        chk("idle_outs", outs, 8'h00);

        // Good key sequence
        request = 1; key = 8'hA5;
        tick();
        chk("good_busy", {busy, error, attempts}, {1'b1, 1'b0, 2'd0});
        request = 0; confirm = 1; inputData = 8'h12;
        #1 chk("good_wp", {writeRegP, writeRegQ}, 2'b10);
        tick();
        chk("good_regp", regp, 7'h12);
        inputData = 8'h34;
        #1 chk("good_wq", {writeRegP, writeRegQ}, 2'b01);
        tick();
        chk("good_regq", regq, 7'h34);
        chk("good_done", {done, busy}, 2'b11);
        confirm = 0;
        tick();
        chk("good_end", outs, 8'h00);
        chk("good_counts", 8'(np * 16 + nq), 8'h11);

        // Bad data then a good P
        request = 1;
        tick();
        request = 0; confirm = 1; inputData = 8'h80;
        #1 chk("bad_nowrite", {writeRegP, writeRegQ}, 2'b00);
        tick();
        chk("bad_err", {busy, error}, 2'b11);
        chk("bad_np", 8'(np), 8'd1);
        inputData = 8'h05;
        #1 chk("bad_then_wp", {writeRegP, writeRegQ}, 2'b10);
        tick();
        chk("bad_regp", regp, 7'h05);
        chk("bad_err_clear", {busy, error}, 2'b10);
        confirm = 0;

        // Reset mid-session in WAIT_Q
        tick();
        chk("rst_pre_busy", busy, 1'b1);
        #1 resetn = 0;
        confirm = 1; inputData = 8'h07;
        #1 chk("rst_async", outs, 8'h00);
        confirm = 0;
        #1 resetn = 1;
        tick();
        chk("rst_idle", outs, 8'h00);
        chk("rst_no_q", 8'(nq), 8'd1);

        // Timeout from WAIT_P
        p0 = np; q0 = nq;
        request = 1;
        tick();
        request = 0;
        repeat (254) tick();
        chk("to_pre", {busy, error}, 2'b10);
        tick();
        chk("to_fire", {busy, error}, 2'b01);
        tick();
        chk("to_after", outs, 8'h00);
        chk("to_nowrite", 8'((np - p0) * 16 + (nq - q0)), 8'h00);

        // Held confirm across three edges
        p0 = np; q0 = nq;
        request = 1;
        tick();
        request = 0; confirm = 1; inputData = 8'h2A;
        tick();
        chk("held_m", {busy, done}, 2'b10);
        tick();
        chk("held_m1", {busy, done}, 2'b11);
        tick();
        chk("held_m2", outs, 8'h00);
        confirm = 0;
        chk("held_writes", 8'((np - p0) * 16 + (nq - q0)), 8'h11);
        chk("held_data", {1'b0, regp}, {1'b0, regq});
        chk("held_regp", regp, 7'h2A);

        // Lockout
        key = 8'h00; request = 1;
        tick();
        chk("lk_try1", {busy, locked, error, attempts}, {3'b001, 2'd1});
        request = 0;
        tick();
        chk("lk_gap1", {error, attempts}, {1'b0, 2'd1});
        request = 1;
        tick();
        chk("lk_try2", {busy, locked, error, attempts}, {3'b001, 2'd2});
        request = 0;
        tick();
        request = 1;
        tick();
        chk("lk_try3", {busy, locked, error, attempts}, {3'b111, 2'd3});
        key = 8'hA5;
        lk = int'(locked);
        repeat (15) begin
            tick();
            lk += int'(locked);
        end
        chk("lk_cycles", 8'(lk), 8'd16);
        chk("lk_ignored", {busy, error, attempts}, {2'b10, 2'd3});
        tick();
        chk("lk_exit", outs, 8'h00);
        request = 0;
        tick();
        chk("lk_no_queue", outs, 8'h00);
        chk("never_both", 8'(both), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
